// File: rtl/cluster_head_announcer.sv
// Cluster-head announce transmitter: serialises 4-word CH announce packets (own or relayed)
// onto a 16-bit valid/ready stream, own announcements taking priority over relays.
module cluster_head_announcer #(
   parameter logic [15:0] MSG_CH_ANNOUNCE = 16'h0003,
   parameter logic [15:0] MAX_HOPS        = 16'd8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_announce_i,
   input  logic        force_announce_i,
   input  logic [15:0] announce_period_i,
   input  logic [15:0] my_ID_i,
   input  logic [15:0] my_QValue_i,
   input  logic        relay_valid_i,
   output logic        relay_ready_o,
   input  logic [15:0] relay_ID_i,
   input  logic [15:0] relay_QValue_i,
   input  logic [15:0] relay_Hops_i,
   output logic        relay_drop_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [15:0] tx_data_o,
   output logic        tx_last_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, HDR, W_ID, W_QV, W_HOPS} state_t;

   state_t      state_q, state_d;
   logic [15:0] id_q, id_d, qv_q, qv_d, hops_q, hops_d;
   logic        isRelay_q, isRelay_d;
   logic        ownPending_q, ownPending_d;
   logic        bufFull_q, bufFull_d;
   logic [15:0] bufId_q, bufId_d, bufQv_q, bufQv_d, bufHops_q, bufHops_d;
   logic        drop_q, drop_d;
   logic [15:0] cnt_q, cnt_d;
   logic        enPrev_q;
   logic        enRise, periodOn, expiry, accept, tooFar, startOwn, startRelay;

   assign enRise   = en_announce_i & ~enPrev_q;
   assign periodOn = en_announce_i & (announce_period_i != 16'd0);
   assign expiry   = periodOn & (cnt_q == 16'd0) & ~enRise;
   assign accept   = relay_valid_i & ~bufFull_q;
   assign tooFar   = relay_Hops_i >= MAX_HOPS;

   always_comb begin
      cnt_d = 16'd0;
      if (periodOn) begin
         if (enRise || expiry) cnt_d = announce_period_i - 16'd1;
         else                  cnt_d = cnt_q - 16'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      startOwn   = 1'b0;
      startRelay = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ownPending_q) begin
               startOwn = 1'b1;
               state_d  = HDR;
            end else if (bufFull_q) begin
               startRelay = 1'b1;
               state_d    = HDR;
            end
         end
         HDR:     if (tx_ready_i) state_d = W_ID;
         W_ID:    if (tx_ready_i) state_d = W_QV;
         W_QV:    if (tx_ready_i) state_d = W_HOPS;
         W_HOPS:  if (tx_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A new request arriving on the same cycle an own packet starts stays pending for the next one.
   always_comb begin
      ownPending_d = (ownPending_q & ~startOwn) | force_announce_i | enRise | expiry;
      id_d         = id_q;
      qv_d         = qv_q;
      hops_d       = hops_q;
      isRelay_d    = isRelay_q;
      if (startOwn) begin
         id_d      = my_ID_i;
         qv_d      = my_QValue_i;
         hops_d    = 16'd0;
         isRelay_d = 1'b0;
      end else if (startRelay) begin
         id_d      = bufId_q;
         qv_d      = bufQv_q;
         hops_d    = bufHops_q;
         isRelay_d = 1'b1;
      end
   end

   // Hop count is incremented on intake; the MAX_HOPS gate guarantees it cannot wrap.
   always_comb begin
      bufFull_d = bufFull_q;
      bufId_d   = bufId_q;
      bufQv_d   = bufQv_q;
      bufHops_d = bufHops_q;
      drop_d    = accept & tooFar;
      if (accept && !tooFar) begin
         bufFull_d = 1'b1;
         bufId_d   = relay_ID_i;
         bufQv_d   = relay_QValue_i;
         bufHops_d = relay_Hops_i + 16'd1;
      end
      if (state_q == W_HOPS && tx_ready_i && isRelay_q) bufFull_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         id_q         <= 16'd0;
         qv_q         <= 16'd0;
         hops_q       <= 16'd0;
         isRelay_q    <= 1'b0;
         ownPending_q <= 1'b0;
         bufFull_q    <= 1'b0;
         bufId_q      <= 16'd0;
         bufQv_q      <= 16'd0;
         bufHops_q    <= 16'd0;
         drop_q       <= 1'b0;
         cnt_q        <= 16'd0;
         enPrev_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         qv_q         <= qv_d;
         hops_q       <= hops_d;
         isRelay_q    <= isRelay_d;
         ownPending_q <= ownPending_d;
         bufFull_q    <= bufFull_d;
         bufId_q      <= bufId_d;
         bufQv_q      <= bufQv_d;
         bufHops_q    <= bufHops_d;
         drop_q       <= drop_d;
         cnt_q        <= cnt_d;
         enPrev_q     <= en_announce_i;
      end
   end

   always_comb begin
      tx_data_o = 16'd0;
      unique case (state_q)
         HDR:     tx_data_o = MSG_CH_ANNOUNCE;
         W_ID:    tx_data_o = id_q;
         W_QV:    tx_data_o = qv_q;
         W_HOPS:  tx_data_o = hops_q;
         default: tx_data_o = 16'd0;
      endcase
   end

   assign tx_valid_o    = (state_q != IDLE);
   assign tx_last_o     = (state_q == W_HOPS);
   assign busy_o        = (state_q != IDLE);
   assign relay_ready_o = ~bufFull_q;
   assign relay_drop_o  = drop_q;

endmodule
